sram_like_arbiter: RTL and testbench

Parametrised N-channel arbiter merging several sram-like master ports (instruction fetch, data access, future prefetch/uncached channels) onto one downstream sram-like port feeding the AXI bridge. Tracks up to DEPTH outstanding requests and routes in-order `dataok`/`rdata` back to the issuing channel through an ID FIFO. Sits between the CPU top and the bus bridge; generalises the fixed inst/data pair of ports.

---
 rtl/sram_like_arbiter_pkg.sv | 16 +
 rtl/sram_like_arbiter_if.sv | 35 +++
 rtl/sram_like_arbiter_id_fifo.sv | 49 ++++
 rtl/sram_like_arbiter.sv | 98 +++++++++
 tb/tb_sram_like_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like channel arbiter: size encodings and
// the channel-ID width helper.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // A single channel still needs a 1-bit ID so the FIFO is never zero-width
    function automatic int ch_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Upstream channel bundle plus downstream sram-like port of the arbiter.
// master = arbiter view, slave = CPU-side channels and bus-bridge view.
interface sram_like_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [NCH-1:0]         ch_req;
    logic [NCH-1:0]         ch_wr;
    logic [NCH-1:0][1:0]    ch_size;
    logic [NCH-1:0][AW-1:0] ch_addr;
    logic [NCH-1:0][DW-1:0] ch_wdata;
    logic [NCH-1:0]         ch_addrok;
    logic [NCH-1:0]         ch_dataok;
    logic [DW-1:0]          ch_rdata;
    logic                   m_req;
    logic                   m_wr;
    logic [1:0]             m_size;
    logic [AW-1:0]          m_addr;
    logic [DW-1:0]          m_wdata;
    logic                   m_addrok;
    logic                   m_dataok;
    logic [DW-1:0]          m_rdata;
    logic                   busy;

    modport master (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata, m_addrok, m_dataok, m_rdata,
        output ch_addrok, ch_dataok, ch_rdata, m_req, m_wr, m_size, m_addr, m_wdata, busy
    );

    modport slave (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wdata, m_addrok, m_dataok, m_rdata,
        input  ch_addrok, ch_dataok, ch_rdata, m_req, m_wr, m_size, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of issuing-channel IDs for accepted requests awaiting dataok.
module sram_like_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: grants one channel onto the downstream port,
// holds the grant until addrok, and routes in-order dataok back via an ID FIFO.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int RR    = 0
) (
    input  logic                clk,
    input  logic                reset,
    sram_like_arbiter_if.master bus
);
    localparam int IDW = ch_idw(NCH);
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [CW-1:0]  cnt;
    logic [IDW-1:0] head, gnt;
    logic [IDW-1:0] lock_ch_q, lock_ch_d, rr_ptr_q, rr_ptr_d;
    logic           lock_vld_q, lock_vld_d;
    logic [NCH-1:0] elig;
    logic           mreq, accept, resp;

    // Search starts at rr_ptr; in fixed mode rr_ptr stays 0 so the lowest index wins
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        elig  = (cnt < CW'(DEPTH)) ? bus.ch_req : '0;
        gnt   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (!found && elig[idx]) begin
                gnt   = IDW'(idx);
                found = 1'b1;
            end
        end
        if (lock_vld_q && elig[lock_ch_q]) gnt = lock_ch_q;
    end

    assign mreq   = |elig;
    assign accept = mreq & bus.m_addrok;
    assign resp   = bus.m_dataok & (cnt != '0);

    always_comb begin
        bus.m_req   = mreq;
        bus.m_wr    = 1'b0;
        bus.m_size  = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (mreq) begin
            bus.m_wr    = bus.ch_wr[gnt];
            bus.m_size  = bus.ch_size[gnt];
            bus.m_addr  = bus.ch_addr[gnt];
            bus.m_wdata = bus.ch_wdata[gnt];
        end
    end

    assign bus.ch_addrok = accept ? (NCH'(1) << gnt)  : '0;
    assign bus.ch_dataok = resp   ? (NCH'(1) << head) : '0;
    assign bus.ch_rdata  = bus.m_rdata;
    assign bus.busy      = (cnt != '0) | mreq;

    // A dropped request on the locked channel simply releases the lock
    always_comb begin
        lock_vld_d = mreq & ~bus.m_addrok;
        lock_ch_d  = mreq ? gnt : lock_ch_q;
        rr_ptr_d   = rr_ptr_q;
        if (RR != 0 && accept)
            rr_ptr_d = (gnt == IDW'(NCH - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_ch_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_ch_q  <= lock_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    sram_like_id_fifo #(.WIDTH(IDW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (resp),
        .din_i   (gnt),
        .head_o  (head),
        .count_o (cnt)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench: fixed-priority NCH=2 instance with a response scoreboard, plus a
// round-robin NCH=3 instance checked for grant order.
module tb_sram_like_arbiter;
    logic clk, reset;
    int   total, bad;

    sram_like_arbiter_if #(.NCH(2), .AW(32), .DW(32)) a ();
    sram_like_arbiter_if #(.NCH(3), .AW(32), .DW(32)) b ();

    sram_like_arbiter #(.NCH(2), .AW(32), .DW(32), .DEPTH(4), .RR(0)) u_dut (
        .clk(clk), .reset(reset), .bus(a.master));
    sram_like_arbiter #(.NCH(3), .AW(32), .DW(32), .DEPTH(4), .RR(1)) u_rr (
        .clk(clk), .reset(reset), .bus(b.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       sb[$];
    logic     mlock_v;
    int       mlock_ch;
    logic [1:0] obs_aok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int g);
        return (g == 0) ? 32'h0000_1000 : 32'h1FC0_0000;
    endfunction

    // One cycle on the fixed-priority instance: drive, check against model, advance model
    task automatic tick(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        logic [1:0] e;
        int g, exp_ch;
        @(negedge clk);
        a.ch_req = req; a.m_addrok = aok; a.m_dataok = dok; a.m_rdata = rd;
        #1;
        e = (sb.size() < 4) ? req : 2'b00;
        if (mlock_v && e[mlock_ch]) g = mlock_ch;
        else g = e[0] ? 0 : 1;
        chk("count",  u_dut.cnt, sb.size());
        chk("m_req",  a.m_req, |e);
        chk("m_addr", a.m_addr, (|e) ? addr_of(g) : 32'h0);
        chk("m_wr",   a.m_wr, (|e) && (g == 1));
        chk("m_size", a.m_size, (|e) ? ((g == 1) ? 2'd1 : 2'd2) : 2'd0);
        chk("addrok", a.ch_addrok, (|e && aok) ? (2'b01 << g) : 2'b00);
        chk("busy",   a.busy, (sb.size() != 0) || (|e));
        obs_aok = a.ch_addrok;
        if (dok && sb.size() > 0) begin
            exp_ch = sb.pop_front();
            chk("dataok", a.ch_dataok, 2'b01 << exp_ch);
            chk("rdata",  a.ch_rdata, rd);
        end else begin
            chk("dataok_idle", a.ch_dataok, 2'b00);
        end
        if (|e && aok) sb.push_back(g);
        mlock_v  = (|e) && !aok;
        mlock_ch = g;
    endtask

    initial begin
        total = 0; bad = 0;
        mlock_v = 1'b0; mlock_ch = 0; obs_aok = '0;
        reset = 1'b1;
        a.ch_req = '0; a.m_addrok = 1'b0; a.m_dataok = 1'b0; a.m_rdata = '0;
        a.ch_wr = 2'b10;
        a.ch_size[0] = 2'd2; a.ch_size[1] = 2'd1;
        a.ch_addr[0] = 32'h0000_1000; a.ch_addr[1] = 32'h1FC0_0000;
        a.ch_wdata[0] = 32'h0; a.ch_wdata[1] = 32'hA5A5_0001;
        b.ch_req = '0; b.ch_wr = '0; b.ch_size = '0; b.ch_wdata = '0;
        for (int i = 0; i < 3; i++) b.ch_addr[i] = 32'h100 * (i + 1);
        b.m_addrok = 1'b0; b.m_dataok = 1'b0; b.m_rdata = 32'hCAFE_0000;

        #2;
        chk("rst_m_req",  a.m_req, 1'b0);
        chk("rst_addrok", a.ch_addrok, 2'b00);
        chk("rst_dataok", a.ch_dataok, 2'b00);
        chk("rst_busy",   a.busy, 1'b0);
        @(negedge clk); reset = 1'b0;

        // fixed priority and in-order routing
        tick(2'b11, 1'b1, 1'b0, 32'h0);
        chk("prio_ch0", obs_aok, 2'b01);
        tick(2'b10, 1'b1, 1'b0, 32'h0);
        chk("prio_ch1", obs_aok, 2'b10);
        tick(2'b00, 1'b0, 1'b1, 32'h1111_1111);
        tick(2'b00, 1'b0, 1'b1, 32'h2222_2222);

        // lock holds ch1 while ch0 arrives
        tick(2'b10, 1'b0, 1'b0, 32'h0);
        tick(2'b11, 1'b0, 1'b0, 32'h0);
        chk("lock_addr", a.m_addr, 32'h1FC0_0000);
        tick(2'b11, 1'b0, 1'b0, 32'h0);
        tick(2'b11, 1'b1, 1'b0, 32'h0);
        chk("lock_acc_ch1", obs_aok, 2'b10);
        tick(2'b01, 1'b1, 1'b0, 32'h0);
        chk("after_lock_ch0", obs_aok, 2'b01);
        tick(2'b00, 1'b0, 1'b1, 32'h0000_0AAA);
        tick(2'b00, 1'b0, 1'b1, 32'h0000_0BBB);

        // full at DEPTH, reopen one cycle after a pop
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b1, 1'b0, 32'h0);
        tick(2'b01, 1'b1, 1'b0, 32'h0);
        chk("full_no_req", a.m_req, 1'b0);
        tick(2'b01, 1'b0, 1'b1, 32'h3333_3333);
        chk("full_pop_cycle", a.m_req, 1'b0);
        tick(2'b01, 1'b0, 1'b0, 32'h0);
        chk("reopen_req", a.m_req, 1'b1);
        tick(2'b00, 1'b0, 1'b1, 32'h0000_0001);

        // simultaneous push/pop at count 2, then drain and a stray dataok
        tick(2'b10, 1'b1, 1'b1, 32'h4444_4444);
        tick(2'b00, 1'b0, 1'b0, 32'h0);
        chk("pushpop_cnt2", u_dut.cnt, 3'd2);
        tick(2'b00, 1'b0, 1'b1, 32'h5555_5555);
        tick(2'b00, 1'b0, 1'b1, 32'h6666_6666);
        tick(2'b00, 1'b0, 1'b1, 32'h7777_7777);
        chk("stray_dataok", a.ch_dataok, 2'b00);

        // reset with three outstanding
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        a.ch_req = '0; a.m_addrok = 1'b0; a.m_dataok = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_busy", a.busy, 1'b0);
        chk("rst_async_cnt",  u_dut.cnt, 3'd0);
        a.m_dataok = 1'b1;
        #1;
        chk("rst_drop_dataok", a.ch_dataok, 2'b00);
        sb.delete(); mlock_v = 1'b0;
        b.ch_req = 3'b111; b.m_addrok = 1'b1; b.m_dataok = 1'b1;

        // round-robin grant order 0,1,2,0,1,2 with responses trailing by one
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("rr_grant", b.ch_addrok, 3'b001 << (k % 3));
            chk("rr_addr",  b.m_addr, 32'h100 * ((k % 3) + 1));
            chk("rr_dataok", b.ch_dataok, (k == 0) ? 3'b000 : (3'b001 << ((k - 1) % 3)));
            chk("drop_no_dataok", a.ch_dataok, 2'b00);
        end
        b.ch_req = '0; b.m_addrok = 1'b0; b.m_dataok = 1'b0;
        a.m_dataok = 1'b0;
        tick(2'b00, 1'b0, 1'b1, 32'h8888_8888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
